handshake_rr_arbiter: RTL

//   Round-robin arbiter sharing one four-phase req/ack handshake responder among NUM_REQ requesters.

---
 rtl/handshake_pkg.sv | 27 ++
 rtl/hs_rr_picker.sv | 47 ++++
 rtl/handshake_rr_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/handshake_pkg.sv
// Shared types and helpers for the handshake round-robin arbiter.
//   hs_arb_state_t : arbiter FSM states
//   HS_MAX_REQ     : largest supported requester count
//   onehot_to_idx  : one-hot (up to HS_MAX_REQ bits) to binary index
package handshake_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        ACK_HI = 2'd2,
        REQ_LO = 2'd3
    } hs_arb_state_t;

    localparam int HS_MAX_REQ = 8;
    localparam int HS_IDX_W   = $clog2(HS_MAX_REQ);

    // Highest set bit wins; callers only pass one-hot or zero vectors.
    function automatic logic [HS_IDX_W-1:0] onehot_to_idx(input logic [HS_MAX_REQ-1:0] oh);
        logic [HS_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < HS_MAX_REQ; i++) begin
            if (oh[i]) idx = HS_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hs_rr_picker.sv
// Combinational rotate-priority encoder.
//   req_i   : request vector
//   ptr_i   : index where the upward (wrapping) search starts
//   valid_o : any request present
//   pick_o  : one-hot winner
//   idx_o   : binary index of the winner
module hs_rr_picker
    import handshake_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDX_W-1:0]   idx_o
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic                  found;
    logic [IDX_W:0]        k;
    logic [HS_MAX_REQ-1:0] pick_ext;
    logic [HS_IDX_W-1:0]   idx_full;

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        k      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (k >= NUM_REQ_W) k = k - NUM_REQ_W;
            if (!found && req_i[k[IDX_W-1:0]]) begin
                pick_o[k[IDX_W-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

    assign valid_o  = |req_i;
    assign pick_ext = HS_MAX_REQ'(pick_o);
    assign idx_full = onehot_to_idx(pick_ext);
    assign idx_o    = idx_full[IDX_W-1:0];

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack responder among
// NUM_REQ requesters, with a stall timeout on the responder side.
//   clk, rst    : clock, asynchronous active-high reset
//   req_i/ack_o : per-requester four-phase handshake
//   srv_req_o   : request to the shared responder
//   srv_ack_i   : ack from the shared responder
//   grant_o     : one-hot owner (0 when idle)
//   grant_id_o  : binary owner (0 when idle)
//   busy_o      : not in IDLE
//   timeout_o   : one-cycle pulse after an aborted transaction
module handshake_rr_arbiter
    import handshake_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int IDX_W          = $clog2(NUM_REQ),
    localparam int CNT_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               srv_req_o,
    input  logic               srv_ack_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_id_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    hs_arb_state_t      state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               pick_valid;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               expired;
    logic               to_idle;
    logic [NUM_REQ-1:0] owner_oh;

    hs_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .pick_o  (pick_oh),
        .idx_o   (pick_idx)
    );

    // Fires on the edge that would complete the TIMEOUT_CYCLES-th waiting
    // cycle, so a stalled phase lasts exactly TIMEOUT_CYCLES cycles.
    assign expired = (TIMEOUT_CYCLES != 0) && ((int'(cnt_q) + 1) >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        timeout_d = 1'b0;
        to_idle   = 1'b0;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                // A high srv_ack_i here is left over from an aborted transfer;
                // wait for it to fall before handing out a new grant.
                if (pick_valid && !srv_ack_i) begin
                    owner_d = pick_idx;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (srv_ack_i) begin
                    state_d = ACK_HI;
                end else if (expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    to_idle   = 1'b1;
                end
            end
            ACK_HI: begin
                if (!req_i[owner_q]) state_d = REQ_LO;
            end
            REQ_LO: begin
                if (!srv_ack_i) begin
                    state_d = IDLE;
                    to_idle = 1'b1;
                end else if (expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    to_idle   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Next search starts just past the last owner.
        if (to_idle) rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == REQ_HI || state_q == REQ_LO) && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Moore decode: outputs depend only on registered state.
    always_comb begin
        owner_oh   = NUM_REQ'(1) << owner_q;
        busy_o     = (state_q != IDLE);
        srv_req_o  = (state_q == REQ_HI) || (state_q == ACK_HI);
        ack_o      = (state_q == ACK_HI || state_q == REQ_LO) ? owner_oh : '0;
        grant_o    = busy_o ? owner_oh : '0;
        grant_id_o = busy_o ? owner_q : '0;
        timeout_o  = timeout_q;
    end

endmodule
